// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM controller.
// Owns one access at a time: IDLE -> ISSUE -> RELEASE, with a per-access timeout.
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_read_valid,
  input  logic              mem_wr_valid,
  input  logic              mem_read_busy,
  input  logic              mem_wr_busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  logic               last;
  logic               owner;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;

  logic               mem_idle;
  logic               any_req;
  logic               pick;
  logic               pick_we;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_wdata;
  logic               hit;
  logic               expire;

  // Winner selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    mem_idle   = !mem_read_busy && !mem_wr_busy;
    any_req    = req0 || req1;
    pick       = (req0 && req1) ? !last : req1;
    pick_we    = pick ? we1 : we0;
    pick_addr  = pick ? addr1 : addr0;
    pick_wdata = pick ? wdata1 : wdata0;
    hit        = we_q ? mem_wr_valid : mem_read_valid;
    expire     = (cnt == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      mem_read_en <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && mem_idle) begin
            state       <= ISSUE;
            owner       <= pick;
            last        <= pick;
            gnt0        <= !pick;
            gnt1        <= pick;
            we_q        <= pick_we;
            mem_addr    <= pick_addr;
            mem_wdata   <= pick_wdata;
            mem_read_en <= !pick_we;
            mem_wr_en   <= pick_we;
            cnt         <= '0;
          end
        end
        ISSUE: begin
          // A matching valid on the final allowed cycle still completes normally.
          if (hit || expire) begin
            state       <= RELEASE;
            mem_read_en <= 1'b0;
            mem_wr_en   <= 1'b0;
            if (hit) begin
              done0 <= !owner;
              done1 <= owner;
              if (!we_q) rdata <= mem_rdata;
            end else begin
              err0 <= !owner;
              err1 <= owner;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (mem_idle) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Parameters, one per line: name, default, meaning.
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.
- TIMEOUT, 255, maximum cycles in ISSUE before abort (8-bit counter).
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req0 / req1, in, 1, requester access request (level; held until done or err).
- we0 / we1, in, 1, 1 = write, 0 = read.
- addr0 / addr1, in, ADDR_W, requester address.
- wdata0 / wdata1, in, DATA_W, requester write data.
- gnt0 / gnt1, out, 1, requester owns the SRAM.
- done0 / done1, out, 1, one-cycle access-complete pulse.
- err0 / err1, out, 1, one-cycle timeout-abort pulse.
- rdata, out, DATA_W, last read data; valid while doneN pulses for a read.
- mem_read_en / mem_wr_en, out, 1, controller enables.
- mem_addr, out, ADDR_W, controller address.
- mem_wdata, out, DATA_W, controller write data.
- mem_rdata, in, DATA_W, controller read data.
- mem_read_valid / mem_wr_valid, in, 1, controller data-valid flags.
- mem_read_busy / mem_wr_busy, in, 1, controller busy flags.

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE and RELEASE.
REQ-005 In IDLE, with at least one reqN high and both mem busy flags low, the block SHALL grant a requester and enter ISSUE on the next edge.
REQ-006 Arbitration SHALL be round-robin:
- a lone requester wins;
- when both request, the one not granted last wins;
- the last-granted pointer updates on each grant.
REQ-007 At grant, the block SHALL latch the winner's addr, we and wdata into mem_addr, mem_wdata and an internal we register; these SHALL stay stable until the FSM returns to IDLE.
REQ-008 gntN SHALL be high from the cycle after the grant decision through the last RELEASE cycle; at most one gnt SHALL ever be high.
REQ-009 In ISSUE, exactly one of mem_read_en / mem_wr_en (per latched we) SHALL be high; both SHALL be low in IDLE and RELEASE.
REQ-010 Read completion: in ISSUE with mem_read_valid high, the block SHALL:
- latch mem_rdata into rdata;
- pulse doneN for the owner on the next cycle;
- enter RELEASE.
REQ-011 Write completion: in ISSUE with mem_wr_valid high, the block SHALL pulse doneN on the next cycle and enter RELEASE.
REQ-012 Timeout: an 8-bit counter SHALL clear on entry to ISSUE and increment each ISSUE cycle. When it reaches TIMEOUT without the matching valid, the block SHALL pulse errN on the next cycle (no doneN) and enter RELEASE.
REQ-013 RELEASE SHALL wait until mem_read_busy and mem_wr_busy are both low, then return to IDLE; gntN SHALL drop on that transition.
REQ-014 Grant-to-enable latency SHALL be 1 cycle; valid-to-done latency SHALL be 1 cycle; minimum access is IDLE, ISSUE, RELEASE, IDLE.
REQ-015 Deassertion of reqN while granted SHALL NOT abort the access; the access SHALL complete normally.
REQ-016 rdata SHALL hold its value between reads and SHALL NOT change on writes.
REQ-017 A valid flag not matching the latched direction SHALL be ignored.

Reset
REQ-018 On rst high at a clock edge, the block SHALL:
- enter IDLE;
- set the round-robin pointer so requester 0 wins the first tie;
- clear the timeout counter;
- drive gnt0/1, done0/1, err0/1, mem_read_en, mem_wr_en low;
- set mem_addr, mem_wdata and rdata to 0.
REQ-019 Reset mid-access SHALL abandon the access with no done/err pulse; rst SHALL override all other inputs.

Verification
REQ-020 Single read: req0=1, we0=0, addr0=0x00012; model returns mem_read_valid with mem_rdata=0xBEEF after 12 cycles -> gnt0 high, mem_read_en high with mem_addr=0x00012, rdata=0xBEEF with done0 one cycle after valid.
REQ-021 Contention: req0 and req1 high together from reset -> requester 0 served first, then requester 1; with both still requesting, requester 0 next; gnt never both high.
REQ-022 Write: req1=1, we1=1, addr1=0x3FFFF, wdata1=0xA5A5 -> mem_wr_en high, mem_addr=0x3FFFF, mem_wdata=0xA5A5; done1 one cycle after mem_wr_valid; rdata unchanged.
REQ-023 Timeout: model never asserts valid, TIMEOUT=8 -> enable high for 8 cycles, then err0 one-cycle pulse with no done0; enables low; IDLE after busy drops.
REQ-024 Busy hold-off: mem_read_busy high while req0 rises -> no grant until busy low; then gnt0 within 1 cycle.
REQ-025 Mid-access reset: assert rst during ISSUE -> next cycle all outputs at reset values; no done/err pulse; the next request is served normally.
